downsizing: RTL and testbench



---
 rtl/downsizing_pkg.sv | 13 +
 rtl/downsizing_if.sv | 42 ++++
 rtl/downsizing_skid.sv | 50 +++++
 rtl/downsizing.sv | 109 ++++++++++
 tb/tb_downsizing.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/downsizing_pkg.sv
// downsizing_pkg: shared types and defaults for the 2W -> W downsizer.
package downsizing_pkg;

  localparam int unsigned DOWNSIZING_W_DEFAULT = 40;

  // State of the main register: which half (if any) is on the output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    UPPER = 2'd1,
    LOWER = 2'd2
  } state_e;

endpackage

// File: rtl/downsizing_if.sv
// downsizing_if: stream bundle for the downsizer (2W-bit input, W-bit output).
// Optional in_tpartial exists only when DOWNSIZING_PARTIAL_EN is defined.
interface downsizing_if #(
  parameter int unsigned W = downsizing_pkg::DOWNSIZING_W_DEFAULT
);
  logic [2*W-1:0] in_tdata;
  logic           in_tvalid;
  logic           in_tready;
`ifdef DOWNSIZING_PARTIAL_EN
  logic           in_tpartial;
`endif
  logic [W-1:0]   out_tdata;
  logic           out_tvalid;
  logic           out_tready;

  // Upstream/downstream environment view.
  modport master (
    output in_tdata,
    output in_tvalid,
`ifdef DOWNSIZING_PARTIAL_EN
    output in_tpartial,
`endif
    input  in_tready,
    input  out_tdata,
    input  out_tvalid,
    output out_tready
  );

  // Downsizer view.
  modport slave (
    input  in_tdata,
    input  in_tvalid,
`ifdef DOWNSIZING_PARTIAL_EN
    input  in_tpartial,
`endif
    output in_tready,
    output out_tdata,
    output out_tvalid,
    input  out_tready
  );

endinterface

// File: rtl/downsizing_skid.sv
// downsizing_skid: one-entry holding buffer with a registered ready.
// ready_o is high exactly when the entry will be empty after this edge.
module downsizing_skid #(
  parameter int unsigned DW = 80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          ready_o
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ready_q;

  // Next entry contents: pop clears, push loads (never both while full).
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (pop_i) begin
      valid_d = 1'b0;
    end
    if (push_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  // Entry registers; ready is held low through the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ~valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/downsizing.sv
// downsizing: splits each 2W-bit input word into two W-bit output words,
// upper half first. A one-entry skid keeps in_tready registered.
// Optional: DOWNSIZING_PARTIAL_EN adds in_tpartial (emit upper half only).
module downsizing
  import downsizing_pkg::*;
#(
  parameter int unsigned W = DOWNSIZING_W_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  downsizing_if.slave bus
);

`ifdef DOWNSIZING_PARTIAL_EN
  localparam int unsigned DW = 2*W + 1;
`else
  localparam int unsigned DW = 2*W;
`endif

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] in_word, skid_data;
  logic          skid_valid, skid_ready, skid_push, skid_pop;
  logic          accept, out_hs, main_partial, exit_pair, main_free;
  logic          lower_bits;

`ifdef DOWNSIZING_PARTIAL_EN
  assign in_word      = {bus.in_tpartial, bus.in_tdata};
  assign main_partial = main_q[DW-1];
`else
  assign in_word      = bus.in_tdata;
  assign main_partial = 1'b0;
`endif

  assign accept     = bus.in_tvalid & skid_ready;
  assign out_hs     = bus.out_tvalid & bus.out_tready;
  // Last half of the current word leaves this cycle.
  assign exit_pair  = out_hs & ((state_q == LOWER) | ((state_q == UPPER) & main_partial));
  // Main can take the incoming word directly (no bubble on LOWER exit).
  assign main_free  = (state_q == EMPTY) | (exit_pair & ~skid_valid);
  assign skid_push  = accept & ~main_free;
  assign skid_pop   = exit_pair & skid_valid;
  assign lower_bits = (state_q == LOWER);

  downsizing_skid #(.DW(DW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .data_i  (in_word),
    .pop_i   (skid_pop),
    .data_o  (skid_data),
    .valid_o (skid_valid),
    .ready_o (skid_ready)
  );

  assign bus.in_tready = skid_ready;

  // Next state and main-register load selection.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_word;
          state_d = UPPER;
        end
      end
      UPPER, LOWER: begin
        if (exit_pair) begin
          if (skid_valid) begin
            main_d  = skid_data;
            state_d = UPPER;
          end else if (accept) begin
            main_d  = in_word;
            state_d = UPPER;
          end else begin
            state_d = EMPTY;
          end
        end else if (out_hs) begin
          state_d = LOWER;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and main data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // Output half select; zero when nothing is held.
  always_comb begin
    bus.out_tdata = '0;
    if (state_q != EMPTY) begin
      bus.out_tdata = lower_bits ? main_q[W-1:0] : main_q[2*W-1:W];
    end
  end

  assign bus.out_tvalid = (state_q != EMPTY);

endmodule

// File: tb/tb_downsizing.sv
// tb_downsizing: directed scoreboard bench for the downsizer.
module tb_downsizing;
  import downsizing_pkg::*;

  localparam int unsigned W = DOWNSIZING_W_DEFAULT;

  localparam logic [2*W-1:0] WA = "ABCDEFGHIJ";
  localparam logic [2*W-1:0] WB = "KLMNOPQRST";
  localparam logic [2*W-1:0] WC = "UVWXYZabcd";
  localparam logic [W-1:0]   S_FGHIJ = "FGHIJ";
  localparam logic [W-1:0]   S_PQRST = "PQRST";

  typedef enum int {RDY_MANUAL, RDY_ON, RDY_TOG, RDY_RND} rdy_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  downsizing_if #(.W(W)) bus ();

  downsizing #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [W-1:0] exp_q[$];
  int           out_cyc[$];
  rdy_e         rdy_mode = RDY_MANUAL;
  bit           sdone;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%h ('%s') want 0x%h ('%s')", name, act, act, expv, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  // Monitor: every output handshake is compared with the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.out_tvalid && bus.out_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%h ('%s') want no output", bus.out_tdata, bus.out_tdata);
      end else begin
        check("sb_word", bus.out_tdata, exp_q.pop_front());
      end
      out_cyc.push_back(cyc);
    end
  end

  // Downstream ready pattern generator.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        RDY_ON:  bus.out_tready = 1'b1;
        RDY_TOG: bus.out_tready = ~bus.out_tready;
        RDY_RND: bus.out_tready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2*W-1:0] d, input logic p);
    bit ok;
    ok = 1'b0;
    bus.in_tdata  = d;
    bus.in_tvalid = 1'b1;
`ifdef DOWNSIZING_PARTIAL_EN
    bus.in_tpartial = p;
`endif
    for (int t = 0; t < 200 && !ok; t++) begin
      if (bus.in_tready) begin
        exp_q.push_back(d[2*W-1:W]);
        if (!p) exp_q.push_back(d[W-1:0]);
        ok = 1'b1;
      end
      tick();
    end
    bus.in_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_tready=0 for 200 cycles want 1");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 1000 && exp_q.size() > 0; t++) tick();
    check_int("drain_left", exp_q.size(), 0);
    exp_q.delete();
    check_int("idle_valid", int'(bus.out_tvalid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_int("rst_out_tvalid", int'(bus.out_tvalid), 0);
    check_int("rst_in_tready", int'(bus.in_tready), 0);
    check("rst_out_tdata", bus.out_tdata, '0);
    check_int("rst_lower_bits", int'(dut.lower_bits), 0);
    rst = 1'b0;
    tick();
    check_int("post_rst_in_tready", int'(bus.in_tready), 1);
  endtask

  task automatic send3();
    send(WA, 1'b0);
    send(WB, 1'b0);
    send(WC, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish within 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_tdata   = '0;
    bus.in_tvalid  = 1'b0;
    bus.out_tready = 1'b0;
`ifdef DOWNSIZING_PARTIAL_EN
    bus.in_tpartial = 1'b0;
`endif
    do_reset();

    // Back-to-back input, always-ready output: six words on consecutive cycles.
    rdy_mode = RDY_ON;
    bus.out_tready = 1'b1;
    out_cyc.delete();
    send3();
    drain();
    check_int("b2b_count", out_cyc.size(), 6);
    if (out_cyc.size() == 6) check_int("b2b_span", out_cyc[5] - out_cyc[0], 5);

    // One valid in four cycles: pairs adjacent, two idle cycles between pairs.
    out_cyc.delete();
    send(WA, 1'b0); repeat (3) tick();
    send(WB, 1'b0); repeat (3) tick();
    send(WC, 1'b0);
    drain();
    check_int("gap_count", out_cyc.size(), 6);
    if (out_cyc.size() == 6) begin
      check_int("gap_pair", out_cyc[1] - out_cyc[0], 1);
      check_int("gap_between", out_cyc[2] - out_cyc[1], 3);
    end

    // Stall 8 cycles while showing FGHIJ with the skid full.
    rdy_mode = RDY_MANUAL;
    bus.out_tready = 1'b0;
    sdone = 1'b0;
    fork
      begin
        send3();
        sdone = 1'b1;
      end
    join_none
    for (int t = 0; t < 20 && !bus.out_tvalid; t++) tick();
    bus.out_tready = 1'b1;
    tick();
    bus.out_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("hold_data", bus.out_tdata, S_FGHIJ);
      check_int("hold_in_tready", int'(bus.in_tready), 0);
      tick();
    end
    rdy_mode = RDY_ON;
    bus.out_tready = 1'b1;
    for (int t = 0; t < 200 && !sdone; t++) tick();
    check_int("hold_sender_done", int'(sdone), 1);
    drain();

    // Toggling ready, starting low then starting high.
    for (int s = 0; s < 2; s++) begin
      rdy_mode = RDY_MANUAL;
      out_cyc.delete();
      bus.out_tready = (s == 0) ? 1'b1 : 1'b0;
      rdy_mode = RDY_TOG;
      repeat (3) send3();
      drain();
      check_int("tog_count", out_cyc.size(), 18);
    end

    // Random ready.
    rdy_mode = RDY_RND;
    out_cyc.delete();
    repeat (4) send3();
    drain();
    check_int("rnd_count", out_cyc.size(), 24);

    // Reset while LOWER holds PQRST: it must never appear.
    rdy_mode = RDY_MANUAL;
    bus.out_tready = 1'b1;
    send(WB, 1'b0);
    tick();
    bus.out_tready = 1'b0;
    check_int("pre_rst_lower", int'(dut.lower_bits), 1);
    check("pre_rst_data", bus.out_tdata, S_PQRST);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_int("mid_rst_out_tvalid", int'(bus.out_tvalid), 0);
    check("mid_rst_out_tdata", bus.out_tdata, '0);
    rst = 1'b0;
    rdy_mode = RDY_ON;
    bus.out_tready = 1'b1;
    tick();
    out_cyc.delete();
    send(WA, 1'b0);
    drain();
    check_int("post_rst_count", out_cyc.size(), 2);

`ifdef DOWNSIZING_PARTIAL_EN
    // Partial word emits only its upper half.
    out_cyc.delete();
    send(WA, 1'b1);
    send(WB, 1'b0);
    drain();
    check_int("partial_count", out_cyc.size(), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
